// File: rtl/agendador_rodadas.sv
// agendador_rodadas: round scheduler that sequences range measurements, retries and scores each round.
// Define PAUSA_EN to add the pausar input, which freezes the timers and stalls the measurement request.
module agendador_rodadas #(
    parameter int N_RODADAS = 4,
    parameter int MAX_TENT  = 3,
    parameter int TIMEOUT   = 2_000_000,
    parameter int INTERVALO = 5_000_000
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           iniciar,
`ifdef PAUSA_EN
    input  logic                           pausar,
`endif
    input  logic                           cfg_we,
    input  logic [$clog2(N_RODADAS)-1:0]   cfg_addr,
    input  logic [11:0]                    cfg_lower,
    input  logic [11:0]                    cfg_upper,
    input  logic                           pronto,
    input  logic                           acertou,
    output logic                           medir,
    output logic [11:0]                    lowerL,
    output logic [11:0]                    upperL,
    output logic [$clog2(N_RODADAS)-1:0]   rodada,
    output logic [$clog2(N_RODADAS):0]     acertos,
    output logic [$clog2(N_RODADAS):0]     erros,
    output logic                           timeout_flag,
    output logic                           fim,
    output logic [3:0]                     db_estado
);
    localparam int AW = $clog2(N_RODADAS);
    localparam int CW = $clog2((TIMEOUT > INTERVALO ? TIMEOUT : INTERVALO) + 1);
    localparam logic [CW-1:0] ULT_TO = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ULT_IV = CW'(INTERVALO - 1);
    localparam logic [AW-1:0] ULT_RD = AW'(N_RODADAS - 1);
    localparam logic [2:0]    ULT_TN = 3'(MAX_TENT - 1);

    typedef enum logic [3:0] {
        OCIOSO      = 4'd0,
        PREPARA     = 4'd1,
        DISPARA     = 4'd2,
        ESPERA      = 4'd3,
        ACERTO      = 4'd4,
        FALHA       = 4'd5,
        INTERVALO_T = 4'd6,
        PROXIMA     = 4'd7,
        FIM         = 4'd8
    } estado_t;

    estado_t       estado;
    logic [CW-1:0] cnt;
    logic [2:0]    tent;
    logic [11:0]   mem_lower [N_RODADAS];
    logic [11:0]   mem_upper [N_RODADAS];
    logic          pausa;

`ifdef PAUSA_EN
    assign pausa = pausar;
`else
    assign pausa = 1'b0;
`endif
    assign fim       = (estado == FIM);
    assign db_estado = estado;

    // cnt is shared: timeout window in ESPERA, inter-attempt/inter-round gap elsewhere
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado       <= OCIOSO;
            cnt          <= '0;
            tent         <= '0;
            medir        <= 1'b0;
            timeout_flag <= 1'b0;
            lowerL       <= '0;
            upperL       <= '0;
            rodada       <= '0;
            acertos      <= '0;
            erros        <= '0;
            for (int i = 0; i < N_RODADAS; i++) begin
                mem_lower[i] <= '0;
                mem_upper[i] <= '0;
            end
        end else begin
            medir        <= 1'b0;
            timeout_flag <= 1'b0;
            if (cfg_we && (estado == OCIOSO || estado == FIM)) begin
                mem_lower[cfg_addr] <= cfg_lower;
                mem_upper[cfg_addr] <= cfg_upper;
            end
            case (estado)
                OCIOSO: begin
                    rodada  <= '0;
                    acertos <= '0;
                    erros   <= '0;
                    tent    <= '0;
                    if (iniciar) estado <= PREPARA;
                end
                PREPARA: begin
                    lowerL <= mem_lower[rodada];
                    upperL <= mem_upper[rodada];
                    estado <= DISPARA;
                end
                DISPARA: if (!pausa) begin
                    medir  <= 1'b1;
                    cnt    <= '0;
                    estado <= ESPERA;
                end
                ESPERA: begin
                    // a pronto landing on the last timeout cycle takes priority
                    if (pronto) estado <= acertou ? ACERTO : FALHA;
                    else if (!pausa) begin
                        if (cnt == ULT_TO) begin
                            timeout_flag <= 1'b1;
                            estado       <= FALHA;
                        end else cnt <= cnt + CW'(1);
                    end
                end
                ACERTO: begin
                    acertos <= acertos + (AW+1)'(1);
                    cnt     <= '0;
                    estado  <= PROXIMA;
                end
                FALHA: begin
                    cnt <= '0;
                    if (tent == ULT_TN) begin
                        erros  <= erros + (AW+1)'(1);
                        estado <= PROXIMA;
                    end else begin
                        tent   <= tent + 3'd1;
                        estado <= INTERVALO_T;
                    end
                end
                INTERVALO_T: if (!pausa) begin
                    if (cnt == ULT_IV) estado <= DISPARA;
                    else cnt <= cnt + CW'(1);
                end
                PROXIMA: begin
                    tent <= '0;
                    if (rodada == ULT_RD) estado <= FIM;
                    else if (!pausa) begin
                        if (cnt == ULT_IV) begin
                            rodada <= rodada + AW'(1);
                            estado <= PREPARA;
                        end else cnt <= cnt + CW'(1);
                    end
                end
                FIM: if (iniciar) estado <= OCIOSO;
                default: estado <= OCIOSO;
            endcase
        end
    end
endmodule
